// File: rtl/multicycle_control.sv
// Multicycle datapath control FSM: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB and drives the datapath controls per state.
module multicycle_control (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  opcode,
   input  logic        zero,
   output logic        SelectIns,
   output logic        RegWrite,
   output logic        RegDst,
   output logic        ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic        MemWrite,
   output logic        MemtoReg,
   output logic        BEQ,
   output logic [1:0]  PCSrc,
   output logic        pc_write,
   output logic        pc_write_cond,
   output logic        ir_write,
   output logic [3:0]  state,
   output logic        halted,
   output logic        illegal,
   output logic [31:0] retired
);

   localparam logic [5:0] OP_LW   = 6'b100000;
   localparam logic [5:0] OP_SW   = 6'b100001;
   localparam logic [5:0] OP_BEQ  = 6'b110000;
   localparam logic [5:0] OP_BNE  = 6'b110001;
   localparam logic [5:0] OP_JMP  = 6'b110010;
   localparam logic [5:0] OP_HALT = 6'b111111;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_EXEC_R   = 4'd2,
      S_EXEC_I   = 4'd3,
      S_MEM_ADDR = 4'd4,
      S_MEM_RD   = 4'd5,
      S_MEM_WR   = 4'd6,
      S_WB_ALU   = 4'd7,
      S_WB_MEM   = 4'd8,
      S_BRANCH   = 4'd9,
      S_JUMP     = 4'd10,
      S_HALT     = 4'd11
   } state_t;

   state_t     st;
   state_t     nxt;
   state_t     dec_nxt;
   logic [5:0] op_q;
   logic       dec_bad;
   logic       fin;

   // Opcode classification; only consulted while in DECODE.
   always_comb begin
      dec_nxt = S_FETCH;
      dec_bad = 1'b0;
      if (opcode[5:4] == 2'b00)
         dec_nxt = S_EXEC_R;
      else if (opcode[5:4] == 2'b01)
         dec_nxt = S_EXEC_I;
      else if (opcode == OP_LW || opcode == OP_SW)
         dec_nxt = S_MEM_ADDR;
      else if (opcode == OP_BEQ || opcode == OP_BNE)
         dec_nxt = S_BRANCH;
      else if (opcode == OP_JMP)
         dec_nxt = S_JUMP;
      else if (opcode == OP_HALT)
         dec_nxt = S_HALT;
      else
         dec_bad = 1'b1;
   end

   // Next-state selection and retire detection.
   always_comb begin
      nxt = S_FETCH;
      fin = 1'b0;
      unique case (st)
         S_FETCH:    nxt = S_DECODE;
         S_DECODE: begin
            nxt = dec_nxt;
            fin = (dec_nxt == S_HALT);
         end
         S_EXEC_R:   nxt = S_WB_ALU;
         S_EXEC_I:   nxt = S_WB_ALU;
         S_MEM_ADDR: nxt = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD:   nxt = S_WB_MEM;
         S_HALT:     nxt = S_HALT;
         S_WB_ALU, S_WB_MEM, S_MEM_WR,
         S_BRANCH, S_JUMP: begin
            nxt = S_FETCH;
            fin = 1'b1;
         end
         default:    nxt = S_FETCH;
      endcase
   end

   // State, latched opcode and status registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         st      <= S_FETCH;
         op_q    <= 6'd0;
         illegal <= 1'b0;
         retired <= 32'd0;
         halted  <= 1'b0;
      end else begin
         st     <= nxt;
         halted <= (nxt == S_HALT);
         if (st == S_DECODE) begin
            op_q <= opcode;
            if (dec_bad)
               illegal <= 1'b1;
         end
         if (fin)
            retired <= retired + 32'd1;
      end
   end

   // Moore decode of the state register; held quiet while rst is high.
   always_comb begin
      SelectIns     = 1'b0;
      RegWrite      = 1'b0;
      RegDst        = 1'b0;
      ALUSrcA       = 1'b0;
      ALUSrcB       = 2'd0;
      MemWrite      = 1'b0;
      MemtoReg      = 1'b0;
      BEQ           = 1'b0;
      PCSrc         = 2'd0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      if (!rst) begin
         unique case (st)
            S_FETCH: begin
               ir_write = 1'b1;
               ALUSrcB  = 2'd1;
               pc_write = 1'b1;
            end
            S_EXEC_R: begin
               ALUSrcA = 1'b1;
            end
            S_EXEC_I, S_MEM_ADDR: begin
               ALUSrcA = 1'b1;
               ALUSrcB = 2'd2;
            end
            S_WB_ALU: begin
               RegWrite = 1'b1;
               RegDst   = (op_q[5:4] == 2'b00);
            end
            S_MEM_RD: begin
               SelectIns = 1'b1;
            end
            S_WB_MEM: begin
               RegWrite = 1'b1;
               MemtoReg = 1'b1;
            end
            S_MEM_WR: begin
               MemWrite  = 1'b1;
               SelectIns = 1'b1;
            end
            S_BRANCH: begin
               ALUSrcA       = 1'b1;
               PCSrc         = 2'd2;
               pc_write_cond = 1'b1;
               BEQ           = (op_q == OP_BNE);
            end
            S_JUMP: begin
               PCSrc    = 2'd2;
               pc_write = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign state = st;

endmodule
